// File: rtl/stack_mem_unit.sv
// -----------------------------------------------------------------------------
// stack_mem_unit
//
// Memory-stage responder for stack and data-memory requests. Owns the stack
// pointer and a word-addressed data RAM. Handles plain load/store, register
// PUSH/POP, and the PC-high / PC-low / flags pushes and pops used by CALL,
// RET, RETI and interrupt entry. A popped PC is reassembled from its two
// halves (low half is popped first) before being returned with pc_load.
//
// Ports:
//   clk, reset        rising-edge clock; asynchronous active-high reset
//   mem_read/write    plain load / store requests (read wins over write)
//   mem_push/pop      stack requests; both at once is a protocol error
//   mem_addsel        plain address: 00 addr_rdst, 01 addr_rsrc, 10 SP, 11 none
//   mem_src_select    push source / pop destination:
//                     00 flags, 01 PC high, 10 PC low, 11 register
//   addr_rdst/rsrc    address operands (low ADDR_W bits used)
//   reg_data, pc, flags  data sources for stores and pushes
//   rd_data/rd_valid      load or register-pop result, strobe one cycle later
//   pc_out/pc_load        reassembled PC after the PC-high pop
//   flags_out/flags_load  popped flags
//   sp_out            current stack pointer
//   stack_err         sticky overflow / underflow / protocol error flag
// -----------------------------------------------------------------------------
module stack_mem_unit #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 16,
    parameter int SP_RESET = 2**ADDR_W - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_push,
    input  logic              mem_pop,
    input  logic [1:0]        mem_addsel,
    input  logic [1:0]        mem_src_select,
    input  logic [15:0]       addr_rdst,
    input  logic [15:0]       addr_rsrc,
    input  logic [15:0]       reg_data,
    input  logic [31:0]       pc,
    input  logic [2:0]        flags,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic [31:0]       pc_out,
    output logic              pc_load,
    output logic [2:0]        flags_out,
    output logic              flags_load,
    output logic [ADDR_W-1:0] sp_out,
    output logic              stack_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_RESET);

    localparam logic [1:0] SRC_FLAGS = 2'b00;
    localparam logic [1:0] SRC_PC_HI = 2'b01;
    localparam logic [1:0] SRC_PC_LO = 2'b10;
    localparam logic [1:0] SRC_REG   = 2'b11;

    typedef enum logic {
        PC_IDLE,
        PC_HAVE_LO
    } pc_state_t;

    // Data RAM (contents are not reset)
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] ram_rdata_q;

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_waddr;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_wdata;

    // State
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              stack_err_q, stack_err_d;
    logic              pend_valid_q, pend_valid_d;
    logic [1:0]        pend_dest_q, pend_dest_d;
    logic [15:0]       rd_data_q, rd_data_d;
    logic [31:0]       pc_out_q, pc_out_d;
    logic [2:0]        flags_out_q, flags_out_d;
    logic [15:0]       lo_q, lo_d;
    pc_state_t         state_q, state_d;

    logic              req_err;
    logic              resp_err;
    logic [ADDR_W-1:0] plain_addr;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] word;

    // Only the low ADDR_W bits of the address operands are meaningful.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_rdst, addr_rsrc};

    assign word = ram_rdata_q;

    always_comb begin
        plain_addr = sp_q;
        case (mem_addsel)
            2'b00:   plain_addr = addr_rdst[ADDR_W-1:0];
            2'b01:   plain_addr = addr_rsrc[ADDR_W-1:0];
            default: plain_addr = sp_q;
        endcase
    end

    always_comb begin
        push_data = DATA_W'(reg_data);
        case (mem_src_select)
            SRC_FLAGS: push_data = {{(DATA_W-3){1'b0}}, flags};
            SRC_PC_HI: push_data = DATA_W'(pc[31:16]);
            SRC_PC_LO: push_data = DATA_W'(pc[15:0]);
            default:   push_data = DATA_W'(reg_data);
        endcase
    end

    // Request side: decode the incoming request, update SP, drive the RAM
    // and remember what the read result (if any) is destined for.
    always_comb begin
        sp_d         = sp_q;
        req_err      = 1'b0;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_waddr    = sp_q;
        ram_raddr    = sp_q + ADDR_W'(1);
        ram_wdata    = push_data;
        pend_valid_d = 1'b0;
        pend_dest_d  = SRC_REG;

        if (mem_push && mem_pop) begin
            req_err = 1'b1;
        end else if (mem_push) begin
            if (sp_q == '0) begin
                req_err = 1'b1;
            end else begin
                ram_we    = 1'b1;
                ram_waddr = sp_q;
                ram_wdata = push_data;
                sp_d      = sp_q - ADDR_W'(1);
            end
        end else if (mem_pop) begin
            if (sp_q == SP_INIT) begin
                req_err = 1'b1;
            end else begin
                ram_re       = 1'b1;
                ram_raddr    = sp_q + ADDR_W'(1);
                sp_d         = sp_q + ADDR_W'(1);
                pend_valid_d = 1'b1;
                pend_dest_d  = mem_src_select;
            end
        end else if (mem_addsel != 2'b11) begin
            if (mem_read) begin
                ram_re       = 1'b1;
                ram_raddr    = plain_addr;
                pend_valid_d = 1'b1;
                pend_dest_d  = SRC_REG;
            end else if (mem_write) begin
                ram_we    = 1'b1;
                ram_waddr = plain_addr;
                ram_wdata = DATA_W'(reg_data);
            end
        end
    end

    // Response side: route the word read last cycle and run the PC
    // reassembly FSM (two-process: state register below, next state here).
    always_comb begin
        rd_valid    = 1'b0;
        pc_load     = 1'b0;
        flags_load  = 1'b0;
        resp_err    = 1'b0;
        rd_data_d   = rd_data_q;
        pc_out_d    = pc_out_q;
        flags_out_d = flags_out_q;
        lo_d        = lo_q;
        state_d     = state_q;

        if (pend_valid_q) begin
            case (pend_dest_q)
                SRC_REG: begin
                    rd_data_d = word[15:0];
                    rd_valid  = 1'b1;
                end
                SRC_FLAGS: begin
                    flags_out_d = word[2:0];
                    flags_load  = 1'b1;
                end
                SRC_PC_LO: begin
                    // A second low pop simply replaces the pending half.
                    lo_d    = word[15:0];
                    state_d = PC_HAVE_LO;
                end
                default: begin
                    if (state_q == PC_HAVE_LO) begin
                        pc_out_d = {word[15:0], lo_q};
                        pc_load  = 1'b1;
                        state_d  = PC_IDLE;
                    end else begin
                        resp_err = 1'b1;
                    end
                end
            endcase
        end

        stack_err_d = stack_err_q | req_err | resp_err;
    end

    assign rd_data   = rd_data_d;
    assign pc_out    = pc_out_d;
    assign flags_out = flags_out_d;
    assign sp_out    = sp_q;
    assign stack_err = stack_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q         <= SP_INIT;
            stack_err_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_dest_q  <= SRC_REG;
            rd_data_q    <= '0;
            pc_out_q     <= '0;
            flags_out_q  <= '0;
            lo_q         <= '0;
            state_q      <= PC_IDLE;
        end else begin
            sp_q         <= sp_d;
            stack_err_q  <= stack_err_d;
            pend_valid_q <= pend_valid_d;
            pend_dest_q  <= pend_dest_d;
            rd_data_q    <= rd_data_d;
            pc_out_q     <= pc_out_d;
            flags_out_q  <= flags_out_d;
            lo_q         <= lo_d;
            state_q      <= state_d;
        end
    end

    // RAM with registered read; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        if (ram_re) begin
            ram_rdata_q <= mem[ram_raddr];
        end
    end

endmodule

// File: tb/tb_stack_mem_unit.sv
module tb_stack_mem_unit;

    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              mem_read, mem_write, mem_push, mem_pop;
    logic [1:0]        mem_addsel, mem_src_select;
    logic [15:0]       addr_rdst, addr_rsrc, reg_data;
    logic [31:0]       pc;
    logic [2:0]        flags;
    logic [15:0]       rd_data;
    logic              rd_valid;
    logic [31:0]       pc_out;
    logic              pc_load;
    logic [2:0]        flags_out;
    logic              flags_load;
    logic [ADDR_W-1:0] sp_out;
    logic              stack_err;

    stack_mem_unit #(.ADDR_W(11), .DATA_W(16), .SP_RESET(2047)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_push(mem_push), .mem_pop(mem_pop),
        .mem_addsel(mem_addsel), .mem_src_select(mem_src_select),
        .addr_rdst(addr_rdst), .addr_rsrc(addr_rsrc), .reg_data(reg_data),
        .pc(pc), .flags(flags),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .pc_out(pc_out), .pc_load(pc_load),
        .flags_out(flags_out), .flags_load(flags_load),
        .sp_out(sp_out), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    // kind: 0 = rd strobe, 1 = pc strobe, 2 = flags strobe
    typedef struct {
        int          kind;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   total_cnt = 0;
    int   pass_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe pops the oldest expectation and must match
    // kind, value and the exact cycle it was predicted for.
    always @(negedge clk) begin
        logic [2:0]  stb;
        logic [31:0] v [3];
        exp_t        e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            total_cnt++;
            $display("FAIL missing_strobe: kind=%0d got no strobe by cycle %0d, required val=%h at cycle %0d",
                     e.kind, cyc, e.val, e.cyc);
        end
        stb  = {flags_load, pc_load, rd_valid};
        v[0] = {16'h0, rd_data};
        v[1] = pc_out;
        v[2] = {29'h0, flags_out};
        for (int k = 0; k < 3; k++) begin
            if (stb[k]) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_strobe: kind=%0d val=%h at cycle %0d, required none", k, v[k], cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind !== k || e.val !== v[k] || e.cyc !== cyc)
                        $display("FAIL strobe: got kind=%0d val=%h cycle=%0d, required kind=%0d val=%h cycle=%0d",
                                 k, v[k], cyc, e.kind, e.val, e.cyc);
                    else begin
                        pass_cnt++;
                        $display("strobe kind=%0d val=%h cycle=%0d ok", k, v[k], cyc);
                    end
                end
            end
        end
    end

    task automatic clr();
        mem_read = 0; mem_write = 0; mem_push = 0; mem_pop = 0;
        mem_addsel = 2'b11; mem_src_select = 2'b11;
        addr_rdst = 0; addr_rsrc = 0; reg_data = 0; pc = 0; flags = 0;
    endtask

    task automatic idle();
        @(posedge clk); #1; clr();
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; clr(); reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic drive_push(input logic [1:0] src, input logic [15:0] d,
                              input logic [31:0] p, input logic [2:0] f);
        @(posedge clk); #1; clr();
        mem_push = 1; mem_addsel = 2'b10; mem_src_select = src;
        reg_data = d; pc = p; flags = f;
    endtask

    task automatic drive_pop(input logic [1:0] src, input int kind, input logic [31:0] val);
        exp_t e;
        @(posedge clk); #1; clr();
        mem_pop = 1; mem_addsel = 2'b10; mem_src_select = src;
        if (kind >= 0) begin
            e.kind = kind; e.val = val; e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_plain(input logic rd, input logic wr, input logic [1:0] sel,
                               input logic [15:0] rdst, input logic [15:0] rsrc,
                               input logic [15:0] d, input int kind, input logic [31:0] val);
        exp_t e;
        @(posedge clk); #1; clr();
        mem_read = rd; mem_write = wr; mem_addsel = sel;
        addr_rdst = rdst; addr_rsrc = rsrc; reg_data = d;
        if (kind >= 0) begin
            e.kind = kind; e.val = val; e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (sp_out !== 11'h7FF) $display("FAIL reset_sp: sp_out=%h required 7ff", sp_out);
        else pass_cnt++;
        total_cnt++;
        if ({stack_err, rd_valid, pc_load, flags_load} !== 4'b0)
            $display("FAIL reset_flags: err/rdv/pcl/fll=%b required 0000", {stack_err, rd_valid, pc_load, flags_load});
        else pass_cnt++;
        total_cnt++;
        if ({rd_data, pc_out, flags_out} !== 51'h0)
            $display("FAIL reset_data: rd=%h pc=%h fl=%b required zeros", rd_data, pc_out, flags_out);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_push_pop();
        drive_push(2'b11, 16'h1234, 32'h0, 3'b0);
        idle();
        total_cnt++;
        if (sp_out !== 11'h7FE) $display("FAIL push_pop_sp_after_push: sp_out=%h required 7fe", sp_out);
        else pass_cnt++;
        drive_pop(2'b11, 0, 32'h1234);
        idle();
        total_cnt++;
        if (sp_out !== 11'h7FF) $display("FAIL push_pop_sp_after_pop: sp_out=%h required 7ff", sp_out);
        else pass_cnt++;
        settle();
        total_cnt++;
        if (exp_q.size() !== 0 || stack_err !== 1'b0)
            $display("FAIL push_pop_end: pending=%0d err=%b required 0/0", exp_q.size(), stack_err);
        else pass_cnt++;
        $display("test_push_pop done");
    endtask

    task automatic test_call();
        drive_push(2'b01, 16'h0, 32'h0001_00A4, 3'b0);
        drive_push(2'b10, 16'h0, 32'h0001_00A4, 3'b0);
        idle();
        total_cnt++;
        if (sp_out !== 11'h7FD) $display("FAIL call_sp_pushed: sp_out=%h required 7fd", sp_out);
        else pass_cnt++;
        drive_pop(2'b10, -1, 32'h0);
        drive_pop(2'b01, 1, 32'h0001_00A4);
        idle();
        settle();
        total_cnt++;
        if (sp_out !== 11'h7FF || exp_q.size() !== 0 || stack_err !== 1'b0)
            $display("FAIL call_end: sp=%h pending=%0d err=%b required 7ff/0/0", sp_out, exp_q.size(), stack_err);
        else pass_cnt++;
        $display("test_call done");
    endtask

    task automatic test_interrupt();
        drive_push(2'b01, 16'hFFFF, 32'hCAFE_1234, 3'b101);
        drive_push(2'b10, 16'hFFFF, 32'hCAFE_1234, 3'b101);
        drive_push(2'b00, 16'hFFFF, 32'hCAFE_1234, 3'b101);
        drive_pop(2'b00, 2, 32'h5);
        drive_pop(2'b10, -1, 32'h0);
        drive_pop(2'b01, 1, 32'hCAFE_1234);
        // flags word must be zero-extended, not polluted by reg_data
        drive_push(2'b00, 16'hFFFF, 32'h0, 3'b011);
        drive_pop(2'b11, 0, 32'h0003);
        idle();
        settle();
        total_cnt++;
        if (sp_out !== 11'h7FF || exp_q.size() !== 0 || stack_err !== 1'b0)
            $display("FAIL interrupt_end: sp=%h pending=%0d err=%b required 7ff/0/0", sp_out, exp_q.size(), stack_err);
        else pass_cnt++;
        total_cnt++;
        if (flags_out !== 3'b101) $display("FAIL interrupt_flags_hold: flags_out=%b required 101", flags_out);
        else pass_cnt++;
        $display("test_interrupt done");
    endtask

    task automatic test_plain();
        drive_plain(0, 1, 2'b01, 16'h0020, 16'h0010, 16'hBEEF, -1, 0);
        drive_plain(1, 0, 2'b00, 16'h0010, 16'h0020, 16'h0, 0, 32'hBEEF);
        drive_plain(1, 0, 2'b00, 16'hF810, 16'h0020, 16'h0, 0, 32'hBEEF);
        drive_plain(0, 1, 2'b00, 16'h0020, 16'h0010, 16'h1111, -1, 0);
        drive_plain(1, 0, 2'b01, 16'h0010, 16'h0020, 16'h0, 0, 32'h1111);
        // read wins: old value returned and the write is dropped
        drive_plain(1, 1, 2'b00, 16'h0010, 16'h0020, 16'h9999, 0, 32'hBEEF);
        drive_plain(1, 0, 2'b00, 16'h0010, 16'h0020, 16'h0, 0, 32'hBEEF);
        drive_plain(0, 1, 2'b10, 16'h0010, 16'h0020, 16'h4242, -1, 0);
        drive_plain(1, 0, 2'b10, 16'h0010, 16'h0020, 16'h0, 0, 32'h4242);
        drive_plain(1, 0, 2'b11, 16'h0010, 16'h0020, 16'h0, -1, 0);
        idle();
        settle();
        total_cnt++;
        if (sp_out !== 11'h7FF || exp_q.size() !== 0 || stack_err !== 1'b0)
            $display("FAIL plain_end: sp=%h pending=%0d err=%b required 7ff/0/0", sp_out, exp_q.size(), stack_err);
        else pass_cnt++;
        $display("test_plain done");
    endtask

    task automatic test_back_to_back();
        drive_push(2'b11, 16'hA001, 32'h0, 3'b0);
        drive_push(2'b11, 16'hA002, 32'h0, 3'b0);
        drive_push(2'b11, 16'hA003, 32'h0, 3'b0);
        drive_pop(2'b11, 0, 32'hA003);
        drive_pop(2'b11, 0, 32'hA002);
        drive_push(2'b11, 16'hA004, 32'h0, 3'b0);
        drive_pop(2'b11, 0, 32'hA004);
        drive_pop(2'b11, 0, 32'hA001);
        idle();
        settle();
        total_cnt++;
        if (sp_out !== 11'h7FF || exp_q.size() !== 0)
            $display("FAIL back_to_back_end: sp=%h pending=%0d required 7ff/0", sp_out, exp_q.size());
        else pass_cnt++;
        $display("test_back_to_back done");
    endtask

    task automatic test_errors();
        do_reset();
        drive_pop(2'b11, -1, 0);
        idle();
        settle();
        total_cnt++;
        if (stack_err !== 1'b1 || sp_out !== 11'h7FF)
            $display("FAIL err_underflow: err=%b sp=%h required 1/7ff", stack_err, sp_out);
        else pass_cnt++;

        do_reset();
        total_cnt++;
        if (stack_err !== 1'b0) $display("FAIL err_cleared_by_reset: err=%b required 0", stack_err);
        else pass_cnt++;
        drive_push(2'b11, 16'h2222, 32'h0, 3'b0);
        @(posedge clk); #1; clr();
        mem_push = 1; mem_pop = 1; mem_addsel = 2'b10; mem_src_select = 2'b11; reg_data = 16'hABCD;
        idle();
        settle();
        total_cnt++;
        if (stack_err !== 1'b1 || sp_out !== 11'h7FE)
            $display("FAIL err_push_and_pop: err=%b sp=%h required 1/7fe", stack_err, sp_out);
        else pass_cnt++;

        do_reset();
        drive_push(2'b11, 16'h3333, 32'h0, 3'b0);
        drive_pop(2'b01, -1, 0);
        idle();
        settle();
        total_cnt++;
        if (stack_err !== 1'b1 || sp_out !== 11'h7FF || exp_q.size() !== 0)
            $display("FAIL err_pc_high_no_low: err=%b sp=%h pending=%0d required 1/7ff/0", stack_err, sp_out, exp_q.size());
        else pass_cnt++;
        $display("test_errors done");
    endtask

    task automatic test_stack_full();
        logic [15:0] v;
        do_reset();
        drive_plain(0, 1, 2'b00, 16'h0000, 16'h0, 16'h0BAD, -1, 0);
        for (int i = 0; i < 2047; i++) begin
            v = 16'(i) ^ 16'hA5A5;
            drive_push(2'b11, v, 32'h0, 3'b0);
        end
        idle();
        total_cnt++;
        if (sp_out !== 11'h000 || stack_err !== 1'b0)
            $display("FAIL full_reached: sp=%h err=%b required 000/0", sp_out, stack_err);
        else pass_cnt++;
        drive_push(2'b11, 16'hDEAD, 32'h0, 3'b0);
        idle();
        total_cnt++;
        if (sp_out !== 11'h000 || stack_err !== 1'b1)
            $display("FAIL full_overflow: sp=%h err=%b required 000/1", sp_out, stack_err);
        else pass_cnt++;
        v = 16'h07FE ^ 16'hA5A5;
        drive_pop(2'b11, 0, {16'h0, v});
        drive_plain(1, 0, 2'b00, 16'h0000, 16'h0, 16'h0, 0, 32'h0BAD);
        idle();
        settle();
        total_cnt++;
        if (sp_out !== 11'h001 || exp_q.size() !== 0)
            $display("FAIL full_pop: sp=%h pending=%0d required 001/0", sp_out, exp_q.size());
        else pass_cnt++;
        $display("test_stack_full done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_push(2'b11, 16'h5555, 32'h0, 3'b0);
        idle();
        reset = 1;
        #1;
        total_cnt++;
        if (sp_out !== 11'h7FF) $display("FAIL async_reset_sp: sp=%h required 7ff", sp_out);
        else pass_cnt++;
        @(posedge clk); #1 reset = 0;

        // pop in flight when reset hits: its strobe must never appear
        drive_push(2'b11, 16'h6666, 32'h0, 3'b0);
        drive_pop(2'b11, -1, 0);
        @(posedge clk); #1; clr(); reset = 1;
        @(posedge clk); #1 reset = 0;
        settle();
        total_cnt++;
        if (sp_out !== 11'h7FF || rd_data !== 16'h0 || exp_q.size() !== 0)
            $display("FAIL reset_drops_read: sp=%h rd=%h pending=%0d required 7ff/0000/0", sp_out, rd_data, exp_q.size());
        else pass_cnt++;

        drive_push(2'b01, 16'h0, 32'h0002_0010, 3'b0);
        drive_push(2'b10, 16'h0, 32'h0002_0010, 3'b0);
        drive_pop(2'b10, -1, 0);
        idle();
        idle();
        do_reset();
        total_cnt++;
        if (sp_out !== 11'h7FF || stack_err !== 1'b0)
            $display("FAIL reset_in_have_lo: sp=%h err=%b required 7ff/0", sp_out, stack_err);
        else pass_cnt++;
        drive_push(2'b11, 16'h7777, 32'h0, 3'b0);
        drive_pop(2'b01, -1, 0);
        idle();
        settle();
        total_cnt++;
        if (stack_err !== 1'b1 || sp_out !== 11'h7FF || exp_q.size() !== 0)
            $display("FAIL pc_high_after_reset: err=%b sp=%h pending=%0d required 1/7ff/0", stack_err, sp_out, exp_q.size());
        else pass_cnt++;
        $display("test_reset_mid done");
    endtask

    initial begin
        clr();
        test_reset();
        test_push_pop();
        test_call();
        test_interrupt();
        test_plain();
        test_back_to_back();
        test_errors();
        test_stack_full();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
